// File: rtl/instr_stream_encoder.sv
// Encodes mnemonic/operand pairs into 9-bit instruction words and writes them to
// instruction memory via a small FIFO. Optional running checksum: ENC_CHECKSUM_EN.
module instr_stream_encoder #(
  parameter int T     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [T-1:0] base_addr_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [4:0]   in_mnem_i,
  input  logic [7:0]   in_opnd_i,
  input  logic         in_last_i,
  output logic         imem_we_o,
  output logic [T-1:0] imem_addr_o,
  output logic [8:0]   imem_wdata_o,
  input  logic         imem_gnt_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [T:0]   word_count_o,
  output logic [8:0]   checksum_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_LOAD  | accepting instructions
  // S_DRAIN | last accepted, flushing FIFO and pending write
  // S_DONE  | one-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [8:0]     fifo_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           we_q, we_d;
  logic [T-1:0]   addr_q, addr_d;
  logic [8:0]     wdata_q, wdata_d;
  logic [T-1:0]   ptr_q, ptr_d;
  logic           ovf_q, ovf_d;
  logic           err_q, err_d;
  logic [T:0]     wcnt_q, wcnt_d;

  logic [8:0]     enc_word;
  logic           enc_legal;
  logic           reg_ok, sform_ok, gform_ok;
  logic           fifo_full, in_ready, accept, push, pop, grant, start_ok;

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b0;
    reg_ok    = (in_opnd_i[7:4] == 4'd0);
    sform_ok  = (in_opnd_i[7:3] == 5'b00001);
    gform_ok  = (in_opnd_i[7:3] == 5'd0);
    unique case (in_mnem_i)
      5'd0:  begin enc_word = {1'b1, in_opnd_i};                   enc_legal = 1'b1;     end
      5'd1:  begin enc_word = {5'b0_0000, in_opnd_i[3:0]};         enc_legal = reg_ok;   end
      5'd2:  begin enc_word = {5'b0_0001, in_opnd_i[3:0]};         enc_legal = reg_ok;   end
      5'd3:  begin enc_word = {5'b0_0010, 1'b0, in_opnd_i[2:0]};   enc_legal = sform_ok; end
      5'd4:  begin enc_word = {5'b0_0010, 1'b1, in_opnd_i[2:0]};   enc_legal = sform_ok; end
      5'd5:  begin enc_word = {5'b0_0011, 1'b0, in_opnd_i[2:0]};   enc_legal = sform_ok; end
      5'd6:  begin enc_word = {5'b0_0011, 1'b1, in_opnd_i[2:0]};   enc_legal = gform_ok; end
      5'd7:  begin enc_word = {5'b0_0100, in_opnd_i[3:0]};         enc_legal = reg_ok;   end
      5'd8:  begin enc_word = {5'b0_0110, in_opnd_i[3:0]};         enc_legal = reg_ok;   end
      5'd9:  begin enc_word = {5'b0_0111, in_opnd_i[3:0]};         enc_legal = reg_ok;   end
      5'd10: begin enc_word = {5'b0_1000, 1'b0, in_opnd_i[2:0]};   enc_legal = gform_ok; end
      5'd11: begin enc_word = {5'b0_1000, 1'b1, in_opnd_i[2:0]};   enc_legal = gform_ok; end
      5'd12: begin enc_word = {5'b0_1001, in_opnd_i[3:0]};         enc_legal = reg_ok;   end
      5'd13: begin enc_word = {5'b0_1010, in_opnd_i[3:0]};         enc_legal = reg_ok;   end
      5'd14: begin enc_word = 9'h0B0;                              enc_legal = 1'b1;     end
      5'd15: begin enc_word = {5'b0_1110, 1'b0, in_opnd_i[2:0]};   enc_legal = gform_ok; end
      5'd16: begin enc_word = {5'b0_1110, 1'b1, in_opnd_i[2:0]};   enc_legal = gform_ok; end
      5'd17: begin enc_word = {5'b0_1111, 1'b0, in_opnd_i[2:0]};   enc_legal = gform_ok; end
      5'd18: begin enc_word = {5'b0_1111, 1'b1, in_opnd_i[2:0]};   enc_legal = gform_ok; end
      default: begin enc_word = '0;                                enc_legal = 1'b0;     end
    endcase
  end

  assign fifo_full = (count_q == (AW+1)'(DEPTH));
  assign in_ready  = (state_q == S_LOAD) && !fifo_full;
  assign accept    = in_valid_i && in_ready;
  assign push      = accept && enc_legal;
  assign grant     = we_q && imem_gnt_i;
  assign pop       = (!we_q || imem_gnt_i) && (count_q != '0);
  assign start_ok  = (state_q == S_IDLE) && start_i;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ptr_d    = ptr_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    wcnt_d   = wcnt_q;

    if (grant) begin
      we_d   = 1'b0;
      wcnt_d = wcnt_q + (T+1)'(1);
      // The top address is writable, but the pointer parks there instead of wrapping.
      if (addr_q == {T{1'b1}}) ovf_d = 1'b1;
      else                     ptr_d = ptr_q + T'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      if (ovf_d) begin
        err_d = 1'b1;
      end else begin
        we_d    = 1'b1;
        addr_d  = ptr_d;
        wdata_d = fifo_q[rd_ptr_q];
      end
    end

    if (accept && !enc_legal) err_d = 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);

    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (!push && pop) count_d = count_q - (AW+1)'(1);

    unique case (state_q)
      S_IDLE:  if (start_i) state_d = S_LOAD;
      S_LOAD:  if (accept && in_last_i) state_d = S_DRAIN;
      S_DRAIN: if ((count_q == '0) && !we_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (start_ok) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      we_d     = 1'b0;
      ptr_d    = base_addr_i;
      ovf_d    = 1'b0;
      err_d    = 1'b0;
      wcnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= enc_word;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ptr_q    <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ptr_q    <= ptr_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      wcnt_q   <= wcnt_d;
    end
  end

`ifdef ENC_CHECKSUM_EN
  logic [8:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (grant)    chk_d = chk_q ^ wdata_q;
    if (start_ok) chk_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) chk_q <= '0;
    else         chk_q <= chk_d;
  end

  assign checksum_o = chk_q;
`else
  assign checksum_o = '0;
`endif

  assign in_ready_o   = in_ready;
  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign busy_o       = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign done_o       = (state_q == S_DONE);
  assign err_o        = err_q;
  assign word_count_o = wcnt_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Directed bench for instr_stream_encoder: scoreboard of expected memory writes
// checked on every granted write, plus session-level status checks.
module tb_instr_stream_encoder;
  localparam int T = 10;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [T-1:0] base_addr;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   in_mnem;
  logic [7:0]   in_opnd;
  logic         in_last;
  logic         imem_we;
  logic [T-1:0] imem_addr;
  logic [8:0]   imem_wdata;
  logic         imem_gnt;
  logic         busy, done, err;
  logic [T:0]   word_count;
  logic [8:0]   checksum;

  int checks = 0;
  int failures = 0;
  logic [T+8:0] exp_q[$];
  int exp_addr;

  always #5 clk = ~clk;

  instr_stream_encoder #(.T(T), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .base_addr_i(base_addr),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_mnem_i(in_mnem),
    .in_opnd_i(in_opnd), .in_last_i(in_last), .imem_we_o(imem_we),
    .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata), .imem_gnt_i(imem_gnt),
    .busy_o(busy), .done_o(done), .err_o(err), .word_count_o(word_count),
    .checksum_o(checksum)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      $error("check %s", tag);
    end
  endtask

  // Every granted write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && imem_we && imem_gnt) begin
      logic [T+8:0] got, want;
      got = {imem_addr, imem_wdata};
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $display("FAIL unexpected_write observed=%0h expected=none", got);
        $error("unexpected write");
      end
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        checks++;
        assert (got === want) else begin
          failures++;
          $display("FAIL write observed=%0h expected=%0h", got, want);
          $error("write mismatch");
        end
      end
    end
  end

  task automatic do_start(input logic [T-1:0] b);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; exp_addr = int'(b);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic send(input logic [4:0] m, input logic [7:0] o, input logic last,
                      input logic legal, input logic [8:0] w);
    int n;
    logic got;
    @(posedge clk); #1;
    in_valid = 1'b1; in_mnem = m; in_opnd = o; in_last = last;
    if (legal) begin
      if (exp_addr <= (1 << T) - 1) exp_q.push_back({T'(exp_addr), w});
      exp_addr++;
    end
    n = 0; got = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      n++;
    end
    chk("accept", 32'(got), 32'd1);
    if (got) @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    logic seen;
    n = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      n++;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
    in_mnem = '0; in_opnd = '0; in_last = 1'b0; imem_gnt = 1'b1; exp_addr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wcnt", 32'(word_count), 32'd0);
    rst = 1'b0;

    // Basic stream with immediate grants
    do_start(10'h010);
    send(5'd0,  8'hA5, 1'b0, 1'b1, 9'h1A5);
    send(5'd7,  8'd3,  1'b0, 1'b1, 9'h043);
    send(5'd3,  8'd9,  1'b0, 1'b1, 9'h021);
    send(5'd18, 8'd2,  1'b0, 1'b1, 9'h0FA);
    send(5'd14, 8'h5C, 1'b1, 1'b1, 9'h0B0);
    wait_done("t1_done");
    chk("t1_wcnt", 32'(word_count), 32'd5);
    chk("t1_err", 32'(err), 32'd0);
`ifdef ENC_CHECKSUM_EN
    chk("t1_checksum", 32'(checksum), 32'h18D);
`else
    chk("t1_checksum", 32'(checksum), 32'h0);
`endif
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // Backpressure: grant withheld, FIFO fills, write port holds
    imem_gnt = 1'b0;
    do_start(10'h020);
    for (int i = 1; i <= 5; i++) send(5'd0, 8'(i), 1'b0, 1'b1, 9'h100 | 9'(i));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t2_ready_low", 32'(in_ready), 32'd0);
      chk("t2_hold", {imem_we, imem_addr, imem_wdata}, {1'b1, 10'h020, 9'h101});
    end
    imem_gnt = 1'b1;
    send(5'd0, 8'd6, 1'b1, 1'b1, 9'h106);
    wait_done("t2_done");
    chk("t2_wcnt", 32'(word_count), 32'd6);
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Illegal operand and illegal mnemonic are dropped
    do_start(10'h040);
    send(5'd3,  8'd5, 1'b0, 1'b0, 9'h000);
    send(5'd25, 8'd0, 1'b0, 1'b0, 9'h000);
    send(5'd1,  8'd2, 1'b1, 1'b1, 9'h002);
    wait_done("t3_done");
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_wcnt", 32'(word_count), 32'd1);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Address overflow at the top of memory
    do_start(10'd1022);
    chk("t4_err_cleared", 32'(err), 32'd0);
    send(5'd0, 8'd1, 1'b0, 1'b1, 9'h101);
    send(5'd0, 8'd2, 1'b0, 1'b1, 9'h102);
    send(5'd0, 8'd3, 1'b1, 1'b1, 9'h103);
    wait_done("t4_done");
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_wcnt", 32'(word_count), 32'd2);
    chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-session aborts everything
    imem_gnt = 1'b0;
    do_start(10'h100);
    send(5'd0, 8'd1, 1'b0, 1'b1, 9'h101);
    send(5'd0, 8'd2, 1'b0, 1'b1, 9'h102);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_rst_outputs",
        {in_ready, imem_we, busy, done, err, 22'(imem_addr), 9'(imem_wdata)}, 32'd0);
    chk("t5_rst_counts", {word_count, checksum}, 20'd0);
    exp_q.delete();
    #1;
    rst = 1'b0; imem_gnt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_no_write", 32'(imem_we), 32'd0);
    end
    do_start(10'h200);
    send(5'd0, 8'h77, 1'b1, 1'b1, 9'h177);
    wait_done("t5_done");
    chk("t5_wcnt", 32'(word_count), 32'd1);
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // Checksum of two words
    do_start(10'h300);
    send(5'd0, 8'hA5, 1'b0, 1'b1, 9'h1A5);
    send(5'd7, 8'd3,  1'b1, 1'b1, 9'h043);
    wait_done("t6_done");
`ifdef ENC_CHECKSUM_EN
    chk("t6_checksum", 32'(checksum), 32'h1E6);
`else
    chk("t6_checksum", 32'(checksum), 32'h0);
`endif
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
